// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear sequencer with centisecond prescaler, cascaded BCD
// mm:ss.cc time counter and a lap-hold display freeze.
//
// state   | meaning
// IDLE    | time at zero, stopped, waiting for start
// RUN     | prescaler counting, time advancing on each tick
// PAUSED  | time and prescaler frozen; resume or clear
module stopwatch_ctrl #(
    parameter int TICK_DIV = 1000000,
    parameter int PRE_W    = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [23:0] time_bcd,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_hold,
    output logic        tick,
    output logic        wrapped
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED} state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t           state;
    logic [PRE_W-1:0] pre;
    logic [23:0]      time_q;
    logic [23:0]      lap_q;

    logic        ss_pls;
    logic        lap_pls;
    logic        advance;
    logic        tc;
    logic [23:0] time_inc;
    logic        wrap;
    logic [3:0]  dig;
    logic [3:0]  lim;
    logic [23:0] time_nxt;
    logic [23:0] lap_nxt;
    logic        lap_hold_nxt;

    // Any pulse of higher priority in the same cycle masks the lower ones;
    // a clear or start_stop in RUN also holds the prescaler for that cycle.
    assign ss_pls  = btn_start_stop & ~btn_clear;
    assign lap_pls = btn_lap & ~btn_start_stop & ~btn_clear;
    assign advance = (state == ST_RUN) && !btn_clear && !btn_start_stop;
    assign tc      = advance && (pre == PRE_LAST);
    assign time_bcd = time_q;

    // Ripple-carry BCD increment; sec and min tens roll over at 5.
    always_comb begin
        time_inc = time_q;
        wrap     = 1'b1;
        dig      = 4'd0;
        lim      = 4'd9;
        for (int i = 0; i < 6; i++) begin
            dig = time_q[i*4 +: 4];
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (wrap) begin
                if (dig >= lim) begin
                    time_inc[i*4 +: 4] = 4'd0;
                end else begin
                    time_inc[i*4 +: 4] = dig + 4'd1;
                    wrap               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        time_nxt     = time_q;
        lap_nxt      = lap_q;
        lap_hold_nxt = lap_hold;
        case (state)
            ST_RUN: begin
                if (lap_pls) begin
                    lap_hold_nxt = !lap_hold;
                    if (!lap_hold) lap_nxt = time_q;
                end
                if (tc) time_nxt = time_inc;
            end
            ST_PAUSED: begin
                if (btn_clear) begin
                    time_nxt     = '0;
                    lap_hold_nxt = 1'b0;
                end else if (lap_pls) begin
                    lap_hold_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pre      <= '0;
            time_q   <= '0;
            lap_q    <= '0;
            disp_bcd <= '0;
            running  <= 1'b0;
            lap_hold <= 1'b0;
            tick     <= 1'b0;
            wrapped  <= 1'b0;
        end else begin
            time_q   <= time_nxt;
            lap_q    <= lap_nxt;
            lap_hold <= lap_hold_nxt;
            disp_bcd <= lap_hold_nxt ? lap_nxt : time_nxt;
            tick     <= tc;
            if (tc && wrap) wrapped <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (ss_pls) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                        pre     <= '0;
                    end
                end
                ST_RUN: begin
                    if (ss_pls) begin
                        state   <= ST_PAUSED;
                        running <= 1'b0;
                    end else if (advance) begin
                        pre <= tc ? '0 : pre + 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (btn_clear) begin
                        state   <= ST_IDLE;
                        pre     <= '0;
                        wrapped <= 1'b0;
                    end else if (btn_start_stop) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, directed corner sequences and random
// buttons checked against a centisecond-count reference model.
module tb_stopwatch_ctrl;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_start_stop = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clear = 1'b0;
    logic [23:0] time_bcd;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_hold;
    logic        tick;
    logic        wrapped;

    int n_cmp = 0;
    int n_bad = 0;

    stopwatch_ctrl #(.TICK_DIV(TD), .PRE_W(3)) dut (
        .clk(clk), .rst(rst),
        .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .time_bcd(time_bcd), .disp_bcd(disp_bcd), .running(running),
        .lap_hold(lap_hold), .tick(tick), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    // Reference model: elapsed time as a plain centisecond count.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2;
    int m_st, m_pre, m_cs, m_lapv;
    bit m_lh, m_wr, m_tick;

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_step(input bit r, input bit ss, input bit lp, input bit cl);
        m_tick = 0;
        if (r) begin
            m_st = M_IDLE; m_pre = 0; m_cs = 0; m_lapv = 0; m_lh = 0; m_wr = 0;
        end else begin
            case (m_st)
                M_IDLE: if (!cl && ss) begin m_st = M_RUN; m_pre = 0; end
                M_RUN: begin
                    if (cl) begin
                    end else if (ss) begin
                        m_st = M_PAUSED;
                    end else begin
                        if (lp) begin
                            if (!m_lh) m_lapv = m_cs;
                            m_lh = !m_lh;
                        end
                        if (m_pre == TD - 1) begin
                            m_pre = 0;
                            m_tick = 1;
                            m_cs = m_cs + 1;
                            if (m_cs == 360000) begin m_cs = 0; m_wr = 1; end
                        end else begin
                            m_pre = m_pre + 1;
                        end
                    end
                end
                default: begin
                    if (cl) begin
                        m_st = M_IDLE; m_cs = 0; m_pre = 0; m_lh = 0; m_wr = 0;
                    end else if (ss) begin
                        m_st = M_RUN;
                    end else if (lp) begin
                        m_lh = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic step(input bit r, input bit ss, input bit lp, input bit cl);
        rst = r; btn_start_stop = ss; btn_lap = lp; btn_clear = cl;
        model_step(r, ss, lp, cl);
        @(negedge clk);
        rst = 0; btn_start_stop = 0; btn_lap = 0; btn_clear = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "/time"}, time_bcd, to_bcd(m_cs));
        chk({tag, "/disp"}, disp_bcd, m_lh ? to_bcd(m_lapv) : to_bcd(m_cs));
        chk({tag, "/running"}, 24'(running), 24'(m_st == M_RUN));
        chk({tag, "/lap_hold"}, 24'(lap_hold), 24'(m_lh));
        chk({tag, "/tick"}, 24'(tick), 24'(m_tick));
        chk({tag, "/wrapped"}, 24'(wrapped), 24'(m_wr));
    endtask

    // btn = {rst, start_stop, lap, clear}; flg = {running, lap_hold, tick, wrapped}
    typedef struct {
        logic [3:0]  btn;
        logic [3:0]  flg;
        logic [23:0] tim;
        logic [23:0] dsp;
    } vec_t;

    vec_t tbl[$];
    bit   r, ss, lp, cl;

    initial begin
        tbl.push_back('{4'b1000, 4'b0000, 24'h0, 24'h0});
        tbl.push_back('{4'b0100, 4'b1000, 24'h0, 24'h0});
        tbl.push_back('{4'b0000, 4'b1000, 24'h0, 24'h0});
        tbl.push_back('{4'b0000, 4'b1000, 24'h0, 24'h0});
        tbl.push_back('{4'b0000, 4'b1000, 24'h0, 24'h0});
        tbl.push_back('{4'b0000, 4'b1010, 24'h1, 24'h1});
        tbl.push_back('{4'b0000, 4'b1000, 24'h1, 24'h1});
        tbl.push_back('{4'b0000, 4'b1000, 24'h1, 24'h1});
        tbl.push_back('{4'b0000, 4'b1000, 24'h1, 24'h1});
        tbl.push_back('{4'b0000, 4'b1010, 24'h2, 24'h2});
        tbl.push_back('{4'b0000, 4'b1000, 24'h2, 24'h2});
        tbl.push_back('{4'b0000, 4'b1000, 24'h2, 24'h2});
        tbl.push_back('{4'b0000, 4'b1000, 24'h2, 24'h2});
        tbl.push_back('{4'b0000, 4'b1010, 24'h3, 24'h3});
        tbl.push_back('{4'b0000, 4'b1000, 24'h3, 24'h3});
        tbl.push_back('{4'b0000, 4'b1000, 24'h3, 24'h3});
        tbl.push_back('{4'b0000, 4'b1000, 24'h3, 24'h3});
        tbl.push_back('{4'b0100, 4'b0000, 24'h3, 24'h3});
        tbl.push_back('{4'b0000, 4'b0000, 24'h3, 24'h3});
        tbl.push_back('{4'b0100, 4'b1000, 24'h3, 24'h3});
        tbl.push_back('{4'b0000, 4'b1010, 24'h4, 24'h4});
        tbl.push_back('{4'b0100, 4'b0000, 24'h4, 24'h4});
        tbl.push_back('{4'b0101, 4'b0000, 24'h0, 24'h0});
        tbl.push_back('{4'b0100, 4'b1000, 24'h0, 24'h0});
        tbl.push_back('{4'b0010, 4'b1100, 24'h0, 24'h0});
        tbl.push_back('{4'b0000, 4'b1100, 24'h0, 24'h0});
        tbl.push_back('{4'b0000, 4'b1100, 24'h0, 24'h0});
        tbl.push_back('{4'b0000, 4'b1110, 24'h1, 24'h0});
        tbl.push_back('{4'b0010, 4'b1000, 24'h1, 24'h1});

        @(negedge clk);

        foreach (tbl[i]) begin
            step(tbl[i].btn[3], tbl[i].btn[2], tbl[i].btn[1], tbl[i].btn[0]);
            chk($sformatf("vec%0d/flags", i), 24'({running, lap_hold, tick, wrapped}), 24'(tbl[i].flg));
            chk($sformatf("vec%0d/time", i), time_bcd, tbl[i].tim);
            chk($sformatf("vec%0d/disp", i), disp_bcd, tbl[i].dsp);
        end

        // Pause two cycles into a period: time frozen, tick two cycles after resume.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0);
            chk("pause_time", time_bcd, 24'h0);
            chk("pause_tick", 24'(tick), 24'h0);
        end
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("resume_tick_early", 24'(tick), 24'h0);
        step(0, 0, 0, 0);
        chk("resume_tick", 24'(tick), 24'h1);
        chk("resume_time", time_bcd, 24'h000001);

        // Carry chain 00:09.99 -> 00:10.00.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int k = 0; k < 5000 && m_cs < 1000; k++) begin
            step(0, 0, 0, 0);
            check_model("run10s");
        end
        chk("carry_10s", time_bcd, 24'h001000);

        // Lap freeze at 00:03.05.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int k = 0; k < 2000 && m_cs < 305; k++) begin
            step(0, 0, 0, 0);
            check_model("run305");
        end
        step(0, 0, 1, 0);
        check_model("lap_on");
        chk("lap_disp", disp_bcd, 24'h000305);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0);
        chk("lap_frozen_disp", disp_bcd, 24'h000305);
        chk("lap_live_time", time_bcd, 24'h000307);
        step(0, 0, 1, 0);
        check_model("lap_off");
        chk("lap_off_disp", disp_bcd, 24'h000307);

        // Wrap 59:59.99 -> 00:00.00: time is deposited while paused.
        step(0, 1, 0, 0);
        force dut.time_q = 24'h595999;
        m_cs = 359999;
        step(0, 0, 0, 0);
        release dut.time_q;
        chk("preload", time_bcd, 24'h595999);
        step(0, 1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 0);
            check_model("to_wrap");
            if (m_tick) break;
        end
        chk("wrap_time", time_bcd, 24'h000000);
        chk("wrap_flag", 24'(wrapped), 24'h1);
        chk("wrap_running", 24'(running), 24'h1);

        // Reset mid-run with lap held and wrapped set.
        step(0, 0, 1, 0);
        chk("pre_rst_lap", 24'(lap_hold), 24'h1);
        step(1, 0, 0, 0);
        chk("rst_flags", 24'({running, lap_hold, tick, wrapped}), 24'h0);
        chk("rst_time", time_bcd, 24'h0);
        chk("rst_disp", disp_bcd, 24'h0);
        step(0, 1, 0, 0);
        for (int k = 1; k < TD; k++) begin
            step(0, 0, 0, 0);
            chk("post_rst_no_tick", 24'(tick), 24'h0);
        end
        step(0, 0, 0, 0);
        chk("post_rst_tick", 24'(tick), 24'h1);
        chk("post_rst_time", time_bcd, 24'h000001);

        // Random button traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 599) == 0);
            ss = ($urandom_range(0, 9) == 0);
            lp = ($urandom_range(0, 7) == 0);
            cl = ($urandom_range(0, 11) == 0);
            step(r, ss, lp, cl);
            check_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
